// File: rtl/ysyx_23060096_regfile_scoreboard.sv
// ysyx_23060096_regfile_scoreboard
//   General-purpose register file for the pipelined NPC core. It has NR_RD combinational
//   read ports and one writeback port. A saturating counter per register tracks how many
//   writes are still pending, so decode/issue can detect operands that are not ready yet.
//   Register 0 always reads as zero and never collects reservations.
//   Optional feature macro: YSYX_23060096_RF_BYPASS_EN
//     When defined, a same-cycle writeback is forwarded straight to matching read ports.
module ysyx_23060096_regfile_scoreboard #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NR_RD      = 2,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NR_RD*ADDR_WIDTH-1:0]    raddr,
    output logic [NR_RD*DATA_WIDTH-1:0]    rdata,
    output logic [NR_RD-1:0]               rbusy,
    input  logic                           issue_valid,
    input  logic [ADDR_WIDTH-1:0]          issue_rd,
    output logic                           issue_ready,
    input  logic                           wb_valid,
    input  logic [ADDR_WIDTH-1:0]          wb_addr,
    input  logic [DATA_WIDTH-1:0]          wb_data,
    input  logic                           flush,
    output logic                           any_pending,
    output logic                           err_uflow
);

    localparam int                   DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] REG_ZERO = {ADDR_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] rf_r  [DEPTH];
    logic [CNT_WIDTH-1:0]  cnt_r [DEPTH];
    logic                  err_uflow_r;

    logic                  issue_ready_s;
    logic                  accept_s;
    logic                  wb_live_s;
    logic [DEPTH-1:0]      inc_s;
    logic [DEPTH-1:0]      dec_s;
    logic                  any_pending_s;

    // A writeback to x0 is discarded entirely, so only nonzero targets count
    assign wb_live_s = wb_valid && (wb_addr != REG_ZERO);

    // Reservation is refused only when the target counter is full and no retire frees a slot
    always_comb begin
        issue_ready_s = (cnt_r[issue_rd] != CNT_MAX) || (wb_valid && (wb_addr == issue_rd));
    end

    assign accept_s    = issue_valid && issue_ready_s && (issue_rd != REG_ZERO);
    assign issue_ready = issue_ready_s;

    // Per-register increment/decrement requests; x0 never gets either
    always_comb begin
        inc_s = {DEPTH{1'b0}};
        dec_s = {DEPTH{1'b0}};
        for (int r = 1; r < DEPTH; r++) begin
            inc_s[r] = accept_s && (issue_rd == ADDR_WIDTH'(r));
            dec_s[r] = wb_valid && (wb_addr == ADDR_WIDTH'(r)) && (cnt_r[r] != CNT_ZERO);
        end
    end

    // Saturating pending counters; flush drops every reservation at once
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < DEPTH; r++) begin
                cnt_r[r] <= CNT_ZERO;
            end
        end else if (flush) begin
            for (int r = 0; r < DEPTH; r++) begin
                cnt_r[r] <= CNT_ZERO;
            end
        end else begin
            cnt_r[0] <= CNT_ZERO;
            for (int r = 1; r < DEPTH; r++) begin
                if (inc_s[r] && !dec_s[r] && (cnt_r[r] != CNT_MAX)) begin
                    cnt_r[r] <= cnt_r[r] + CNT_WIDTH'(1);
                end else if (dec_s[r] && !inc_s[r]) begin
                    cnt_r[r] <= cnt_r[r] - CNT_WIDTH'(1);
                end else begin
                    cnt_r[r] <= cnt_r[r];
                end
            end
        end
    end

    // Register array write; data lands even on underflow or during a flush
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < DEPTH; r++) begin
                rf_r[r] <= {DATA_WIDTH{1'b0}};
            end
        end else if (wb_live_s) begin
            rf_r[wb_addr] <= wb_data;
        end else begin
            rf_r[wb_addr] <= rf_r[wb_addr];
        end
    end

    // Sticky underflow flag: a retire to a register with nothing outstanding
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_uflow_r <= 1'b0;
        end else if (!flush && wb_live_s && (cnt_r[wb_addr] == CNT_ZERO)) begin
            err_uflow_r <= 1'b1;
        end else begin
            err_uflow_r <= err_uflow_r;
        end
    end

    assign err_uflow = err_uflow_r;

    // Any outstanding reservation anywhere in the file
    always_comb begin
        any_pending_s = 1'b0;
        for (int r = 0; r < DEPTH; r++) begin
            any_pending_s = any_pending_s | (cnt_r[r] != CNT_ZERO);
        end
    end

    assign any_pending = any_pending_s;

    for (genvar k = 0; k < NR_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra_s;
        logic [DATA_WIDTH-1:0] rd_data_s;
        logic                  rd_busy_s;

        assign ra_s = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];

        // Operand read for this port; x0 reads zero and is never busy
        always_comb begin
            rd_data_s = {DATA_WIDTH{1'b0}};
            rd_busy_s = 1'b0;
            if (ra_s == REG_ZERO) begin
                rd_data_s = {DATA_WIDTH{1'b0}};
                rd_busy_s = 1'b0;
            end else begin
`ifdef YSYX_23060096_RF_BYPASS_EN
                if (wb_valid && (wb_addr == ra_s)) begin
                    rd_data_s = wb_data;
                    rd_busy_s = (cnt_r[ra_s] > CNT_WIDTH'(1));
                end else begin
                    rd_data_s = rf_r[ra_s];
                    rd_busy_s = (cnt_r[ra_s] != CNT_ZERO);
                end
`else
                rd_data_s = rf_r[ra_s];
                rd_busy_s = (cnt_r[ra_s] != CNT_ZERO);
`endif
            end
        end

        assign rdata[k*DATA_WIDTH +: DATA_WIDTH] = rd_data_s;
        assign rbusy[k]                          = rd_busy_s;
    end

endmodule

// File: tb/tb_ysyx_23060096_regfile_scoreboard.sv
// Directed bench for ysyx_23060096_regfile_scoreboard with three read ports.
// Expectations adapt to whether YSYX_23060096_RF_BYPASS_EN is defined.
module tb_ysyx_23060096_regfile_scoreboard;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 3;

    logic              clk;
    logic              rstn;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;
    logic [NR-1:0]     rbusy;
    logic              issue_valid;
    logic [AW-1:0]     issue_rd;
    logic              issue_ready;
    logic              wb_valid;
    logic [AW-1:0]     wb_addr;
    logic [DW-1:0]     wb_data;
    logic              flush;
    logic              any_pending;
    logic              err_uflow;

    int tests_run;
    int tests_failed;

    ysyx_23060096_regfile_scoreboard #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_RD(NR), .CNT_WIDTH(2)
    ) dut (
        .clk(clk), .rstn(rstn), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .any_pending(any_pending), .err_uflow(err_uflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        wb_valid    = 1'b0;
        wb_addr     = 5'd0;
        wb_data     = 32'h0;
        flush       = 1'b0;
    endtask

    task automatic set_raddr(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
        raddr = {a2, a1, a0};
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rstn = 1'b0;
        idle();
        set_raddr(5'd5, 5'd0, 5'd0);
        #12;
        rstn = 1'b1;
        #1;

        // Reset state
        check("rst_rdata", {64'h0, rdata[31:0]}, 96'h0);
        check("rst_rbusy", {93'h0, rbusy}, 96'h0);
        check("rst_ready", {95'h0, issue_ready}, 96'h1);
        check("rst_pending", {95'h0, any_pending}, 96'h0);
        check("rst_err", {95'h0, err_uflow}, 96'h0);

        // Basic: reserve x5 then retire it
        issue_valid = 1'b1; issue_rd = 5'd5;
        #1;
        check("basic_ready", {95'h0, issue_ready}, 96'h1);
        tick();
        idle();
        #1;
        check("basic_busy", {95'h0, rbusy[0]}, 96'h1);
        check("basic_pending", {95'h0, any_pending}, 96'h1);
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        #1;
`ifdef YSYX_23060096_RF_BYPASS_EN
        check("basic_wb_rdata", {64'h0, rdata[31:0]}, 96'hDEADBEEF);
        check("basic_wb_busy", {95'h0, rbusy[0]}, 96'h0);
`else
        check("basic_wb_rdata", {64'h0, rdata[31:0]}, 96'h0);
        check("basic_wb_busy", {95'h0, rbusy[0]}, 96'h1);
`endif
        tick();
        idle();
        #1;
        check("basic_after_rdata", {64'h0, rdata[31:0]}, 96'hDEADBEEF);
        check("basic_after_busy", {95'h0, rbusy[0]}, 96'h0);
        check("basic_after_pending", {95'h0, any_pending}, 96'h0);
        check("basic_after_err", {95'h0, err_uflow}, 96'h0);

        // Saturation on x7
        set_raddr(5'd5, 5'd7, 5'd0);
        issue_valid = 1'b1; issue_rd = 5'd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("sat_fill_ready", {95'h0, issue_ready}, 96'h1);
            tick();
        end
        #1;
        check("sat_full_x7", {95'h0, issue_ready}, 96'h0);
        issue_rd = 5'd8;
        #1;
        check("sat_x8_ready", {95'h0, issue_ready}, 96'h1);
        issue_rd = 5'd7; wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
        #1;
        check("sat_wb_ready", {95'h0, issue_ready}, 96'h1);
        tick();
        wb_valid = 1'b0;
        #1;
        check("sat_still_full", {95'h0, issue_ready}, 96'h0);
        check("sat_busy", {95'h0, rbusy[1]}, 96'h1);
        issue_valid = 1'b0;
        wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h78;
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        idle();
        #1;
        check("sat_drained_busy", {95'h0, rbusy[1]}, 96'h0);
        check("sat_drained_pending", {95'h0, any_pending}, 96'h0);
        check("sat_drained_err", {95'h0, err_uflow}, 96'h0);
        check("sat_drained_data", {64'h0, rdata[63:32]}, 96'h78);

        // x0 is inert: reserve x5 first so any_pending is 1
        issue_valid = 1'b1; issue_rd = 5'd5;
        tick();
        idle();
        set_raddr(5'd5, 5'd7, 5'd0);
        issue_valid = 1'b1; issue_rd = 5'd0;
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
        #1;
        check("x0_ready", {95'h0, issue_ready}, 96'h1);
        tick();
        idle();
        #1;
        check("x0_rdata", {64'h0, rdata[95:64]}, 96'h0);
        check("x0_busy", {95'h0, rbusy[2]}, 96'h0);
        check("x0_pending", {95'h0, any_pending}, 96'h1);
        check("x0_err", {95'h0, err_uflow}, 96'h0);
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h0505;
        tick();
        idle();
        #1;
        check("x0_clear_pending", {95'h0, any_pending}, 96'h0);

        // Flush with concurrent writeback to x1
        set_raddr(5'd1, 5'd2, 5'd6);
        issue_valid = 1'b1; issue_rd = 5'd1;
        tick();
        issue_rd = 5'd2;
        tick();
        idle();
        #1;
        check("fl_busy_before", {93'h0, rbusy}, 96'h3);
        flush = 1'b1; wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'h55;
        tick();
        idle();
        #1;
        check("fl_pending", {95'h0, any_pending}, 96'h0);
        check("fl_busy_after", {93'h0, rbusy}, 96'h0);
        check("fl_x1_data", {64'h0, rdata[31:0]}, 96'h55);
        check("fl_err", {95'h0, err_uflow}, 96'h0);
        // Flush while retiring an idle register must not flag underflow
        flush = 1'b1; wb_valid = 1'b1; wb_addr = 5'd6; wb_data = 32'h66;
        tick();
        idle();
        #1;
        check("fl_idle_err", {95'h0, err_uflow}, 96'h0);
        check("fl_x6_data", {64'h0, rdata[95:64]}, 96'h66);

        // Underflow on x3
        set_raddr(5'd3, 5'd2, 5'd6);
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
        tick();
        idle();
        #1;
        check("uf_err", {95'h0, err_uflow}, 96'h1);
        check("uf_data", {64'h0, rdata[31:0]}, 96'h33);
        check("uf_no_wrap", {95'h0, rbusy[0]}, 96'h0);
        tick();
        check("uf_sticky", {95'h0, err_uflow}, 96'h1);

        // Multi-port read of x9 during its writeback
        set_raddr(5'd9, 5'd9, 5'd9);
        wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'hA5A5A5A5;
        #1;
`ifdef YSYX_23060096_RF_BYPASS_EN
        check("mp_same_cycle", rdata, {3{32'hA5A5A5A5}});
`else
        check("mp_same_cycle", rdata, 96'h0);
`endif
        tick();
        idle();
        #1;
        check("mp_next_cycle", rdata, {3{32'hA5A5A5A5}});

        // Asynchronous reset in mid-cycle with counters nonzero
        set_raddr(5'd3, 5'd7, 5'd9);
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        tick();
        tick();
        idle();
        issue_rd = 5'd7;
        #1;
        check("ar_pre_pending", {95'h0, any_pending}, 96'h1);
        check("ar_pre_ready", {95'h0, issue_ready}, 96'h0);
        rstn = 1'b0;
        #1;
        check("ar_rdata", rdata, 96'h0);
        check("ar_rbusy", {93'h0, rbusy}, 96'h0);
        check("ar_pending", {95'h0, any_pending}, 96'h0);
        check("ar_ready", {95'h0, issue_ready}, 96'h1);
        check("ar_err", {95'h0, err_uflow}, 96'h0);
        rstn = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
